// File: rtl/add_pkg.sv
// Shared types and configuration helpers for the pipelined adder/subtractor.
// The z flag field exists only when ADD_PIPE_Z_EN is defined.
package add_pkg;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
`ifdef ADD_PIPE_Z_EN
        logic z;
`endif
    } flags_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Elaboration-time legality of the width/depth pair
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe; z is present only with ADD_PIPE_Z_EN.
interface add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             n;
`ifdef ADD_PIPE_Z_EN
    logic             z;

    modport master (output in_valid, a, b, sub, out_ready,
                    input  in_ready, out_valid, s, c, v, n, z);
    modport slave  (input  in_valid, a, b, sub, out_ready,
                    output in_ready, out_valid, s, c, v, n, z);
`else
    modport master (output in_valid, a, b, sub, out_ready,
                    input  in_ready, out_valid, s, c, v, n);
    modport slave  (input  in_valid, a, b, sub, out_ready,
                    output in_ready, out_valid, s, c, v, n);
`endif
endinterface

// File: rtl/add_chunk.sv
// Combinational CW-bit adder slice with carry-in, carry-out and carry into its MSB.
module add_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);
    logic [CW:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum    = full_s[CW-1:0];
    assign cout   = full_s[CW];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out directly
    assign cmsb   = a[CW-1] ^ b[CW-1] ^ full_s[CW-1];
endmodule

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: one CW-bit chunk per stage, skewed operands, deskewed result.
// Optional zero flag port and per-chunk zero detect enabled by ADD_PIPE_Z_EN.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    add_pipe_if.slave bus
);
    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $fatal(1, "add_pipe: WIDTH must be a multiple of STAGES");
    end

    logic             stall_s;
    logic             adv_s;
    logic [WIDTH-1:0] b_inv_s;
    flags_t           flags_r;

    // A stalled head freezes the whole pipe, so the input side sees the same stall
    assign stall_s      = bus.out_valid && !bus.out_ready;
    assign adv_s        = !stall_s;
    assign bus.in_ready = adv_s;
    assign b_inv_s      = bus.b ^ {WIDTH{bus.sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int IW = WIDTH - k * CW;
        localparam int PW = (k + 1) * CW;

        logic [IW-1:0] a_in_s;
        logic [IW-1:0] b_in_s;
        logic          cin_s;
        logic          vld_in_s;
        logic [PW-1:0] s_nxt_s;
        logic [CW-1:0] sum_s;
        logic          cout_s;
        logic          vld_r;
        logic [PW-1:0] s_r;
`ifdef ADD_PIPE_Z_EN
        logic          zin_s;
`endif

        if (k == 0) begin : g_head
            assign a_in_s   = bus.a;
            assign b_in_s   = b_inv_s;
            assign cin_s    = bus.sub;
            assign vld_in_s = bus.in_valid;
            assign s_nxt_s  = sum_s;
`ifdef ADD_PIPE_Z_EN
            assign zin_s    = 1'b1;
`endif
        end else begin : g_body
            assign a_in_s   = g_stg[k-1].g_fwd.a_r;
            assign b_in_s   = g_stg[k-1].g_fwd.b_r;
            assign cin_s    = g_stg[k-1].g_fwd.cy_r;
            assign vld_in_s = g_stg[k-1].vld_r;
            assign s_nxt_s  = {sum_s, g_stg[k-1].s_r};
`ifdef ADD_PIPE_Z_EN
            assign zin_s    = g_stg[k-1].g_fwd.z_r;
`endif
        end

        // Stage valid bit and deskewed low result bits; held while stalled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                s_r   <= {PW{1'b0}};
            end else if (adv_s) begin
                vld_r <= vld_in_s;
                s_r   <= s_nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int RW = IW - CW;

            logic          cmsb_unused;
            logic [RW-1:0] a_r;
            logic [RW-1:0] b_r;
            logic          cy_r;
`ifdef ADD_PIPE_Z_EN
            logic          z_r;
`endif

            add_chunk #(.CW(CW)) u_chunk (
                .a    (a_in_s[CW-1:0]),
                .b    (b_in_s[CW-1:0]),
                .cin  (cin_s),
                .sum  (sum_s),
                .cout (cout_s),
                .cmsb (cmsb_unused)
            );

            // Skew registers: operand bits not yet consumed plus the chunk carry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r  <= {RW{1'b0}};
                    b_r  <= {RW{1'b0}};
                    cy_r <= 1'b0;
`ifdef ADD_PIPE_Z_EN
                    z_r  <= 1'b0;
`endif
                end else if (adv_s) begin
                    a_r  <= a_in_s[IW-1:CW];
                    b_r  <= b_in_s[IW-1:CW];
                    cy_r <= cout_s;
`ifdef ADD_PIPE_Z_EN
                    z_r  <= zin_s && (sum_s == {CW{1'b0}});
`endif
                end
            end
        end else begin : g_tail
            logic cmsb_s;

            add_chunk #(.CW(CW)) u_chunk (
                .a    (a_in_s[CW-1:0]),
                .b    (b_in_s[CW-1:0]),
                .cin  (cin_s),
                .sum  (sum_s),
                .cout (cout_s),
                .cmsb (cmsb_s)
            );

            // Flags come from the MSB chunk, registered alongside the final sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_r.c <= 1'b0;
                    flags_r.v <= 1'b0;
                    flags_r.n <= 1'b0;
`ifdef ADD_PIPE_Z_EN
                    flags_r.z <= 1'b0;
`endif
                end else if (adv_s) begin
                    flags_r.c <= cout_s;
                    flags_r.v <= cmsb_s ^ cout_s;
                    flags_r.n <= sum_s[CW-1];
`ifdef ADD_PIPE_Z_EN
                    flags_r.z <= zin_s && (sum_s == {CW{1'b0}});
`endif
                end
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].vld_r;
    assign bus.s         = g_stg[STAGES-1].s_r;
    assign bus.c         = flags_r.c;
    assign bus.v         = flags_r.v;
    assign bus.n         = flags_r.n;
`ifdef ADD_PIPE_Z_EN
    assign bus.z         = flags_r.z;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed vectors, stall, reset flush and random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_add_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_pipe_if #(.WIDTH(WIDTH)) bus ();

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        int          tick;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_tick = 0;
    int          retired = 0;
    bit          lat_en = 1'b0;
    bit          accepted = 1'b0;
    bit          held = 1'b0;
    logic [31:0] hs;
    logic        hc, hv, hn, hz;
    logic [31:0] last_s;
    logic        last_c, last_v, last_n, last_z;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned and signed arithmetic on wide integers
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t   e;
        longint sa, sbv, sr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sub) begin
            e.s = a - b;
            e.c = (a >= b);
            sr  = sa - sbv;
        end else begin
            {e.c, e.s} = {1'b0, a} + {1'b0, b};
            sr  = sa + sbv;
        end
        e.v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.n    = e.s[31];
        e.z    = (e.s == 32'd0);
        e.tick = 0;
        return e;
    endfunction

    logic obs_z;
`ifdef ADD_PIPE_Z_EN
    assign obs_z = bus.z;
`else
    assign obs_z = 1'b0;
`endif

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cur_tick++;
        accepted = 1'b0;
        if (rst_n) check1("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (held) begin
            check1("hold_valid", bus.out_valid, 1'b1);
            check32("hold_s", bus.s, hs);
            check1("hold_c", bus.c, hc);
            check1("hold_v", bus.v, hv);
            check1("hold_n", bus.n, hn);
`ifdef ADD_PIPE_Z_EN
            check1("hold_z", obs_z, hz);
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check1("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check32("s", bus.s, e.s);
                check1("c", bus.c, e.c);
                check1("v", bus.v, e.v);
                check1("n", bus.n, e.n);
`ifdef ADD_PIPE_Z_EN
                check1("z", obs_z, e.z);
`endif
                if (lat_en) check32("latency", 32'(cur_tick - e.tick), 32'(STAGES));
                last_s = bus.s; last_c = bus.c; last_v = bus.v; last_n = bus.n; last_z = obs_z;
                retired++;
            end
        end
        if (rst_n && bus.in_valid && bus.in_ready) begin
            e      = model(bus.a, bus.b, bus.sub);
            e.tick = cur_tick;
            sb.push_back(e);
            accepted = 1'b1;
        end
        held = rst_n && bus.out_valid && !bus.out_ready;
        hs = bus.s; hc = bus.c; hv = bus.v; hn = bus.n; hz = obs_z;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        check1("drained", sb.size() == 0, 1'b1);
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        check1("accepted", accepted, 1'b1);
        bus.in_valid = 1'b0;
        drain();
    endtask

    task automatic check_last(input string tag, input logic [31:0] s,
                              input logic c, input logic v, input logic n, input logic z);
        check32({tag, "_s"}, last_s, s);
        check1({tag, "_c"}, last_c, c);
        check1({tag, "_v"}, last_v, v);
        check1({tag, "_n"}, last_n, n);
`ifdef ADD_PIPE_Z_EN
        check1({tag, "_z"}, last_z, z);
`else
        if (z) check1({tag, "_z_model"}, z, 1'b1);
`endif
    endtask

    initial begin
        int i;
        int base;
        bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.sub = 1'b0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check32("rst_s", bus.s, 32'd0);
        check1("rst_c", bus.c, 1'b0);
        check1("rst_v", bus.v, 1'b0);
        check1("rst_n_flag", bus.n, 1'b0);
        check1("rst_z", obs_z, 1'b0);
        rst_n = 1'b1;
        tick();
        check1("in_ready_after_reset", bus.in_ready, 1'b1);

        // Directed flag vectors with latency checking
        lat_en = 1'b1;
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_last("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_last("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        send_one(32'd5, 32'd5, 1'b1);
        check_last("sub_eq", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        send_one(32'd3, 32'd5, 1'b1);
        check_last("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        send_one(32'h8000_0000, 32'h0000_0001, 1'b1);
        check_last("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Eight back-to-back beats with the consumer stalling for cycles 5-7
        lat_en = 1'b0;
        base = retired;
        i = 0;
        for (int cyc = 0; cyc < 40 && i < 8; cyc++) begin
            bus.a = 32'(i); bus.b = 32'(32'h10 * i); bus.sub = 1'b0; bus.in_valid = 1'b1;
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            tick();
            if (accepted) i++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check32("burst_accepted", 32'(i), 32'd8);
        drain();
        check32("burst_retired", 32'(retired - base), 32'd8);

        // Random traffic with random back-pressure
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(9) < 7);
            bus.sub       = $urandom_range(1) == 1;
            case ($urandom_range(7))
                0: bus.a = 32'h8000_0000;
                1: bus.a = 32'hFFFF_FFFF;
                default: bus.a = $urandom;
            endcase
            bus.b = ($urandom_range(5) == 0) ? bus.a : $urandom;
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drain();

        // Reset two cycles after accepting three beats flushes them
        for (int k = 0; k < 3; k++) begin
            bus.a = $urandom; bus.b = $urandom; bus.sub = 1'b0; bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check1("flush_out_valid", bus.out_valid, 1'b0);
        sb.delete();
        held = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = retired;
        for (int k = 0; k < 8; k++) tick();
        check32("no_stale", 32'(retired - base), 32'd0);
        lat_en = 1'b1;
        send_one(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        check32("post_reset_retired", 32'(retired - base), 32'd1);
        check_last("post_reset", 32'h0246_8ACF, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
